// File: rtl/avalon_enforcer_pkg.sv
// Shared types and helpers for the Avalon-ST framing enforcer.
package avalon_enforcer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    DROP   = 2'd2
  } enforcer_state_t;

  // A one-byte bus still carries a 1-bit empty field so the port never collapses to zero width.
  function automatic int empty_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST stream bundle: data, valid, sop, eop, empty forward; rdy backward.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EMPTY_W = avalon_enforcer_pkg::empty_width(DATA_WIDTH_IN_BYTES);

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;
  logic                             rdy;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_st_pipe_stage.sv
// One-deep registered Avalon-ST stage; accepts whenever the holding register is empty or draining.
module avalon_st_pipe_stage #(
  parameter int DATA_W  = 128,
  parameter int EMPTY_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_i,
  input  logic [DATA_W-1:0]  in_data_i,
  input  logic               in_sop_i,
  input  logic               in_eop_i,
  input  logic [EMPTY_W-1:0] in_empty_i,
  output logic               in_rdy_o,
  output logic               out_valid_o,
  output logic [DATA_W-1:0]  out_data_o,
  output logic               out_sop_o,
  output logic               out_eop_o,
  output logic [EMPTY_W-1:0] out_empty_o,
  input  logic               out_rdy_i
);

  logic               valid_q;
  logic [DATA_W-1:0]  data_q;
  logic               sop_q;
  logic               eop_q;
  logic [EMPTY_W-1:0] empty_q;

  assign in_rdy_o = !valid_q || out_rdy_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
    end else if (in_rdy_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        data_q  <= in_data_i;
        sop_q   <= in_sop_i;
        eop_q   <= in_eop_i;
        empty_q <= in_empty_i;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_sop_o   = sop_q;
  assign out_eop_o   = eop_q;
  assign out_empty_o = empty_q;

endmodule

// File: rtl/avalon_framing_enforcer.sv
// Repairs SOP/EOP/EMPTY framing of an untrusted Avalon-ST stream and reports every violation.
module avalon_framing_enforcer
  import avalon_enforcer_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int MAX_PKT_BEATS       = 64,
  parameter int ERR_CNT_WIDTH       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  avalon_st_if.slave               untrusted_msg,
  avalon_st_if.master              enforced_msg,
  output logic                     missing_sop_indi,
  output logic                     unexpected_sop_indi,
  output logic                     overlength_indi,
  output logic                     bad_empty_indi,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  localparam int DATA_W  = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EMPTY_W = empty_width(DATA_WIDTH_IN_BYTES);
  localparam int CNT_W   = $clog2(MAX_PKT_BEATS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT_BEATS);

  enforcer_state_t    state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d, beat_cnt_inc;
  logic               accept, fwd;
  logic               sop_r, eop_r;
  logic [EMPTY_W-1:0] empty_r;
  logic               miss_d, unexp_d, ovl_d, bad_d;
  logic               miss_q, unexp_q, ovl_q, bad_q;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
  logic [ERR_CNT_WIDTH:0]   err_sum;
  logic [2:0]               err_inc;

  assign accept       = untrusted_msg.valid && untrusted_msg.rdy;
  assign beat_cnt_inc = beat_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    fwd        = 1'b0;
    sop_r      = untrusted_msg.sop;
    eop_r      = untrusted_msg.eop;
    empty_r    = untrusted_msg.empty;
    miss_d     = 1'b0;
    unexp_d    = 1'b0;
    ovl_d      = 1'b0;
    if (accept) begin
      case (state_q)
        IN_PKT: begin
          fwd = 1'b1;
          if (untrusted_msg.sop) begin
            // Close the open packet on this beat; its new payload is not trusted.
            sop_r      = 1'b0;
            eop_r      = 1'b1;
            empty_r    = '0;
            unexp_d    = 1'b1;
            beat_cnt_d = '0;
            state_d    = untrusted_msg.eop ? IDLE : DROP;
          end else if (untrusted_msg.eop) begin
            beat_cnt_d = '0;
            state_d    = IDLE;
          end else if (beat_cnt_inc == MAX_CNT) begin
            eop_r      = 1'b1;
            empty_r    = '0;
            ovl_d      = 1'b1;
            beat_cnt_d = '0;
            state_d    = DROP;
          end else begin
            beat_cnt_d = beat_cnt_inc;
          end
        end
        default: begin
          // IDLE and DROP both restart on sop; only IDLE flags a stray beat.
          if (untrusted_msg.sop) begin
            fwd = 1'b1;
            if (untrusted_msg.eop) begin
              beat_cnt_d = '0;
              state_d    = IDLE;
            end else begin
              beat_cnt_d = CNT_W'(1);
              state_d    = IN_PKT;
            end
          end else if (state_q == IDLE) begin
            miss_d = 1'b1;
          end else if (untrusted_msg.eop) begin
            state_d = IDLE;
          end
        end
      endcase
    end
    bad_d = fwd && !untrusted_msg.eop && (untrusted_msg.empty != '0);
    if (bad_d) empty_r = '0;
  end

  assign err_inc = {2'b00, miss_d} + {2'b00, unexp_d} + {2'b00, ovl_d} + {2'b00, bad_d};
  assign err_sum = {1'b0, err_q} + (ERR_CNT_WIDTH + 1)'(err_inc);
  assign err_d   = err_sum[ERR_CNT_WIDTH] ? '1 : err_sum[ERR_CNT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      miss_q     <= 1'b0;
      unexp_q    <= 1'b0;
      ovl_q      <= 1'b0;
      bad_q      <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      miss_q     <= miss_d;
      unexp_q    <= unexp_d;
      ovl_q      <= ovl_d;
      bad_q      <= bad_d;
      err_q      <= err_d;
    end
  end

  avalon_st_pipe_stage #(
    .DATA_W  (DATA_W),
    .EMPTY_W (EMPTY_W)
  ) u_out_stage (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (fwd),
    .in_data_i   (untrusted_msg.data),
    .in_sop_i    (sop_r),
    .in_eop_i    (eop_r),
    .in_empty_i  (empty_r),
    .in_rdy_o    (untrusted_msg.rdy),
    .out_valid_o (enforced_msg.valid),
    .out_data_o  (enforced_msg.data),
    .out_sop_o   (enforced_msg.sop),
    .out_eop_o   (enforced_msg.eop),
    .out_empty_o (enforced_msg.empty),
    .out_rdy_i   (enforced_msg.rdy)
  );

  assign missing_sop_indi    = miss_q;
  assign unexpected_sop_indi = unexp_q;
  assign overlength_indi     = ovl_q;
  assign bad_empty_indi      = bad_q;
  assign err_cnt             = err_q;

endmodule

// File: tb/tb_avalon_framing_enforcer.sv
// Directed table-driven bench for avalon_framing_enforcer with MAX_PKT_BEATS=4.
module tb_avalon_framing_enforcer;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss, unexp, ovl, bad;
  logic [15:0] err_cnt;
  int          checks = 0;
  int          errors = 0;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) u_in ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) u_out ();

  avalon_framing_enforcer #(
    .DATA_WIDTH_IN_BYTES (16),
    .MAX_PKT_BEATS       (4),
    .ERR_CNT_WIDTH       (16)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .untrusted_msg       (u_in),
    .enforced_msg        (u_out),
    .missing_sop_indi    (miss),
    .unexpected_sop_indi (unexp),
    .overlength_indi     (ovl),
    .bad_empty_indi      (bad),
    .err_cnt             (err_cnt)
  );

  always #5 clk = ~clk;

  // ind = {missing, unexpected, overlength, bad_empty}
  typedef struct {
    logic       v, s, e;
    logic [3:0] emp;
    logic [7:0] db;
    logic       ev, es, ee;
    logic [3:0] eemp;
    logic [3:0] ind;
    int         ecnt;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(logic v, logic s, logic e, logic [3:0] emp, logic [7:0] db,
                              logic ev, logic es, logic ee, logic [3:0] eemp,
                              logic [3:0] ind, int ecnt);
    vec_t r;
    r.v = v; r.s = s; r.e = e; r.emp = emp; r.db = db;
    r.ev = ev; r.es = es; r.ee = ee; r.eemp = eemp; r.ind = ind; r.ecnt = ecnt;
    return r;
  endfunction

  task automatic drive(logic v, logic s, logic e, logic [3:0] emp, logic [7:0] db);
    u_in.valid = v;
    u_in.sop   = s;
    u_in.eop   = e;
    u_in.empty = emp;
    u_in.data  = {16{db}};
  endtask

  task automatic check(string nm, logic ev, logic es, logic ee, logic [3:0] eemp,
                       logic [7:0] edb, logic [3:0] ind, int ecnt);
    logic         ok;
    logic [127:0] ed;
    ed = {16{edb}};
    ok = (u_out.valid == ev) && ({miss, unexp, ovl, bad} == ind) && (err_cnt == 16'(ecnt));
    if (ev)
      ok = ok && (u_out.sop == es) && (u_out.eop == ee) && (u_out.empty == eemp) && (u_out.data == ed);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got v=%0b s=%0b e=%0b emp=%0d d=%h ind=%b err=%0d, want v=%0b s=%0b e=%0b emp=%0d d=%h ind=%b err=%0d",
               nm, u_out.valid, u_out.sop, u_out.eop, u_out.empty, u_out.data[7:0],
               {miss, unexp, ovl, bad}, err_cnt, ev, es, ee, eemp, edb, ind, ecnt);
    end else begin
      $display("ok   %s: v=%0b s=%0b e=%0b emp=%0d ind=%b err=%0d",
               nm, u_out.valid, u_out.sop, u_out.eop, u_out.empty, {miss, unexp, ovl, bad}, err_cnt);
    end
  endtask

  task automatic check_rdy(string nm, logic exp_rdy);
    checks++;
    if (u_in.rdy !== exp_rdy) begin
      errors++;
      $display("FAIL %s: untrusted rdy got %0b want %0b", nm, u_in.rdy, exp_rdy);
    end else begin
      $display("ok   %s: untrusted rdy=%0b", nm, u_in.rdy);
    end
  endtask

  initial begin
    //            v  s  e  emp  db      ev es ee eemp ind      err
    // missing sop then a 2-beat packet
    vecs[0]  = mk(1, 0, 0, 0, 8'hff,  0, 0, 0, 0, 4'b1000, 1);
    vecs[1]  = mk(1, 1, 0, 0, 8'h01,  1, 1, 0, 0, 4'b0000, 1);
    vecs[2]  = mk(1, 0, 1, 3, 8'h02,  1, 0, 1, 3, 4'b0000, 1);
    // unexpected sop closes packet, remainder dropped
    vecs[3]  = mk(1, 1, 0, 0, 8'h03,  1, 1, 0, 0, 4'b0000, 1);
    vecs[4]  = mk(1, 0, 0, 0, 8'h04,  1, 0, 0, 0, 4'b0000, 1);
    vecs[5]  = mk(1, 1, 0, 0, 8'h05,  1, 0, 1, 0, 4'b0100, 2);
    vecs[6]  = mk(1, 0, 0, 0, 8'h06,  0, 0, 0, 0, 4'b0000, 2);
    vecs[7]  = mk(1, 0, 1, 0, 8'h07,  0, 0, 0, 0, 4'b0000, 2);
    // 6-beat packet truncated at 4
    vecs[8]  = mk(1, 1, 0, 0, 8'h08,  1, 1, 0, 0, 4'b0000, 2);
    vecs[9]  = mk(1, 0, 0, 0, 8'h09,  1, 0, 0, 0, 4'b0000, 2);
    vecs[10] = mk(1, 0, 0, 0, 8'h0a,  1, 0, 0, 0, 4'b0000, 2);
    vecs[11] = mk(1, 0, 0, 0, 8'h0b,  1, 0, 1, 0, 4'b0010, 3);
    vecs[12] = mk(1, 0, 0, 0, 8'h0c,  0, 0, 0, 0, 4'b0000, 3);
    vecs[13] = mk(1, 0, 1, 0, 8'h0d,  0, 0, 0, 0, 4'b0000, 3);
    // bad empty on non-eop beat, legal empty on eop beat
    vecs[14] = mk(1, 1, 0, 0, 8'h0e,  1, 1, 0, 0, 4'b0000, 3);
    vecs[15] = mk(1, 0, 0, 15, 8'h0f, 1, 0, 0, 0, 4'b0001, 4);
    vecs[16] = mk(1, 0, 1, 5, 8'h10,  1, 0, 1, 5, 4'b0000, 4);
    // overlength and bad empty on the same beat
    vecs[17] = mk(1, 1, 0, 0, 8'h11,  1, 1, 0, 0, 4'b0000, 4);
    vecs[18] = mk(1, 0, 0, 0, 8'h12,  1, 0, 0, 0, 4'b0000, 4);
    vecs[19] = mk(1, 0, 0, 0, 8'h13,  1, 0, 0, 0, 4'b0000, 4);
    vecs[20] = mk(1, 0, 0, 7, 8'h14,  1, 0, 1, 0, 4'b0011, 6);
    // sop&eop ends DROP silently
    vecs[21] = mk(1, 1, 1, 2, 8'h15,  1, 1, 1, 2, 4'b0000, 6);
    // valid low ignores garbage framing
    vecs[22] = mk(0, 0, 0, 9, 8'h16,  0, 0, 0, 0, 4'b0000, 6);
    // unexpected sop carrying eop returns to IDLE
    vecs[23] = mk(1, 1, 0, 0, 8'h17,  1, 1, 0, 0, 4'b0000, 6);
    vecs[24] = mk(1, 1, 1, 9, 8'h18,  1, 0, 1, 0, 4'b0100, 7);
    vecs[25] = mk(1, 0, 1, 3, 8'h19,  0, 0, 0, 0, 4'b1000, 8);

    rst = 1'b1;
    u_out.rdy = 1'b1;
    drive(0, 0, 0, 0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (u_out.valid !== 1'b0 || u_out.data !== '0 || u_out.sop !== 1'b0 || u_out.eop !== 1'b0 ||
        u_out.empty !== '0 || {miss, unexp, ovl, bad} !== 4'b0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: v=%0b d=%h s=%0b e=%0b emp=%0d ind=%b err=%0d, want all zero",
               u_out.valid, u_out.data[7:0], u_out.sop, u_out.eop, u_out.empty,
               {miss, unexp, ovl, bad}, err_cnt);
    end else begin
      $display("ok   reset_state");
    end
    check_rdy("reset_rdy", 1'b1);

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].v, vecs[i].s, vecs[i].e, vecs[i].emp, vecs[i].db);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].es, vecs[i].ee, vecs[i].eemp,
            vecs[i].db, vecs[i].ind, vecs[i].ecnt);
    end

    // Backpressure: output beat held for three cycles while rdy is low.
    u_out.rdy = 1'b0;
    drive(1, 1, 1, 15, 8'hf0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 8'h00);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("hold%0d", c), 1, 1, 1, 15, 8'hf0, 4'b0000, 8);
      check_rdy($sformatf("hold_rdy%0d", c), 1'b0);
      if (c < 2) begin
        @(posedge clk);
        #1;
      end
    end
    u_out.rdy = 1'b1;
    #1;
    check_rdy("release_rdy", 1'b1);
    @(posedge clk);
    #1;
    check("drained", 0, 0, 0, 0, 8'h00, 4'b0000, 8);

    // Reset in the middle of an open packet.
    drive(1, 1, 0, 0, 8'h21);
    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 8'h22);
    @(posedge clk);
    #1;
    check("pre_reset", 1, 0, 0, 0, 8'h22, 4'b0000, 8);
    drive(0, 0, 0, 0, 8'h00);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("in_reset", 0, 0, 0, 0, 8'h00, 4'b0000, 0);
    rst = 1'b0;
    drive(1, 0, 1, 0, 8'h23);
    @(posedge clk);
    #1;
    check("post_reset_eop", 0, 0, 0, 0, 8'h00, 4'b1000, 1);
    drive(1, 1, 1, 0, 8'h24);
    @(posedge clk);
    #1;
    check("post_reset_pkt", 1, 1, 1, 0, 8'h24, 4'b0000, 1);
    drive(0, 0, 0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_framing_enforcer.md
# avalon_framing_enforcer

Parametrised framing enforcer for Avalon-ST streams. Sits between an untrusted Avalon-ST source and trusted downstream logic, guaranteeing that every beat leaving it belongs to a legally framed packet. Repairs missing and unexpected SOP, over-length packets and illegal EMPTY values. Reports each violation as a one-cycle indication plus a saturating error counter, so one block serves every ingress port regardless of data width or maximum packet length.

## Interface
Parameters:
- DATA_WIDTH_IN_BYTES, 16, data bus width in bytes; empty width is $clog2(DATA_WIDTH_IN_BYTES).
- MAX_PKT_BEATS, 64, maximum legal packet length in beats (≥2).
- ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- untrusted_msg  avalon_st_if.slave  DATA_WIDTH_IN_BYTES  input stream (data, valid, sop, eop, empty; rdy driven by this block).
- enforced_msg  avalon_st_if.master  DATA_WIDTH_IN_BYTES  repaired output stream.
- missing_sop_indi  out  1  pulse: beat outside a packet without sop.
- unexpected_sop_indi  out  1  pulse: sop inside an open packet.
- overlength_indi  out  1  pulse: packet reached MAX_PKT_BEATS without eop.
- bad_empty_indi  out  1  pulse: nonzero empty on a non-eop beat.
- err_cnt  out  ERR_CNT_WIDTH  saturating count of all indications since reset.

## Operation
- Beat accepted when untrusted_msg.valid && untrusted_msg.rdy. untrusted_msg.rdy = !out_valid_q || enforced_msg.rdy. Dropped beats are still accepted (consumed).
- FSM states: IDLE (no packet open), IN_PKT, DROP. beat_cnt counts forwarded beats of the current packet.
- IDLE: sop&eop → forward, stay IDLE. sop&!eop → forward, beat_cnt=1, go IN_PKT. !sop → drop, missing_sop_indi, stay IDLE.
- IN_PKT, no sop: forward; eop → IDLE. Else beat_cnt+1. If beat_cnt+1 == MAX_PKT_BEATS → force eop=1, empty=0, overlength_indi, go DROP.
- IN_PKT, sop: forward the beat with sop=0, eop=1, empty=0 to close the current packet; unexpected_sop_indi. If the beat had eop → IDLE, else DROP.
- DROP: !sop → drop; eop → IDLE. sop → end drop, process exactly as in IDLE; no indication.
- Any forwarded beat with eop=0 and empty≠0 → empty forced to 0, bad_empty_indi. This also applies to beats whose eop is forced.
- Several indications may pulse on the same beat. err_cnt adds the number asserted (0–2) and saturates at all-ones.
- Data is never modified; only sop, eop and empty are repaired.

## Timing
- Latency: 1 cycle, input accept to enforced_msg.valid, via a registered output stage. Full throughput: 1 beat/cycle with rdy high.
- Output holds data/sop/eop/empty/valid stable while valid && !rdy.
- Indications are registered: asserted for exactly one cycle, the cycle after the offending beat is accepted; err_cnt updates in the same cycle.
- Reset values: enforced_msg.valid=0, data=0, sop=0, eop=0, empty=0; all indications 0; err_cnt=0; FSM=IDLE; beat_cnt=0. untrusted_msg.rdy=1 in the cycle after reset.
- Reset mid-packet discards the open packet and any held output beat; no eop is emitted. The next input beat is judged from IDLE.
- untrusted_msg.valid low: no state change, no indication, regardless of sop/eop/empty values.

## Structure
- Package avalon_enforcer_pkg: enforcer_state_t enum (IDLE, IN_PKT, DROP) and the function computing empty width from DATA_WIDTH_IN_BYTES.
- Sub-module avalon_st_pipe_stage: one-deep registered output stage with the rdy rule above, reusable by other Avalon-ST blocks. FSM, repair logic and counters live in the top.

## Test plan
(MAX_PKT_BEATS=4, DATA_WIDTH_IN_BYTES=16, enforced_msg.rdy=1 unless stated.)
- Beat 0xff.. without sop in IDLE, then sop beat, then eop beat → first beat dropped, missing_sop_indi one pulse, 2-beat packet out one cycle later, err_cnt=1.
- sop, plain, sop (new), plain, eop → output sop, plain, eop-closed third beat; last two beats dropped; unexpected_sop_indi once; FSM IDLE after.
- 6-beat packet sop..eop → 4 beats out, 4th with eop=1 empty=0; beats 5–6 dropped; overlength_indi once.
- Non-eop beat with empty=4'b1111, then eop beat with empty=5 → output empty 0 then 5; bad_empty_indi once.
- sop&eop beat with data 0xf0.. and empty=15 while enforced_msg.rdy=0 for 3 cycles → output held stable 3 cycles, untrusted_msg.rdy low; delivered unchanged; no indication.
- Reset asserted after 2 beats of an open packet, then eop-only beat → output valid 0, err_cnt 0 during reset; afterwards beat dropped with missing_sop_indi.
